// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: upstream immediate push side and
// downstream extended-result pop side.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender (sign/zero/upper/branch) behind a 2-entry skid buffer.
// Define IMM_EXT_STATS_EN to add the 16-bit out_count completed-pop counter.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  imm_extend_pipe_if.slave bus
`ifdef IMM_EXT_STATS_EN
  ,
  output logic [15:0]      out_count
`endif
);
  localparam int PAD = OUT_W - IN_W;

  typedef enum logic [1:0] {M_SIGN, M_ZERO, M_UPPER, M_BRANCH} mode_e;

  logic [1:0][OUT_W-1:0] mem;
  logic                  rptr, wptr;
  logic [1:0]            count;
  logic                  push, pop;
  logic [OUT_W-1:0]      sext, ext;

  always_comb begin
    sext = {{PAD{bus.in_imm[IN_W-1]}}, bus.in_imm};
    ext  = sext;
    case (mode_e'(bus.in_mode))
      M_SIGN:   ext = sext;
      M_ZERO:   ext = {{PAD{1'b0}}, bus.in_imm};
      M_UPPER:  ext = {bus.in_imm, {PAD{1'b0}}};
      M_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
      default:  ext = sext;
    endcase
  end

  // Ready comes from count alone so out_ready never reaches in_ready.
  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = mem[rptr];
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      mem   <= '0;
    end else if (flush) begin
      count <= 2'd0;
      rptr  <= 1'b0;
      wptr  <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= ext;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef IMM_EXT_STATS_EN
  // A pop squashed by flush never completed, so it is not counted.
  always_ff @(posedge clk) begin
    if (rst)               out_count <= 16'd0;
    else if (pop & ~flush) out_count <= out_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed plan with literal expectations plus a
// randomized run checked every cycle against a queue-based reference model.
module tb_imm_extend_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

`ifdef IMM_EXT_STATS_EN
  logic [15:0] out_count;
  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .out_count(out_count));
`else
  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus));
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit rst_prev = 1'b0;
  logic [31:0] q[$];
  int pops_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension from plain integer arithmetic.
  function automatic logic [31:0] model_ext(input int imm, input int mode);
    longint s, r;
    s = (imm >= 32768) ? longint'(imm) - 65536 : longint'(imm);
    case (mode)
      0: r = s;
      1: r = imm;
      2: r = longint'(imm) * 65536;
      default: r = s * 4;
    endcase
    return r[31:0];
  endfunction

  always @(posedge clk) begin
    bit push, pop;
    rst_prev = rst;
    if (rst) begin
      q.delete();
      pops_m = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      pop  = (q.size() != 0) && bus.out_ready;
      push = bus.in_valid && (q.size() != 2);
      if (pop) begin
        void'(q.pop_front());
        pops_m = (pops_m + 1) % 65536;
      end
      if (push) q.push_back(model_ext(int'(bus.in_imm), int'(bus.in_mode)));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("m_in_ready", 32'(bus.in_ready), 32'(q.size() != 2));
      if (q.size() != 0) chk("m_out_data", bus.out_data, q[0]);
      if (rst_prev) chk("m_rst_data", bus.out_data, 32'h0);
`ifdef IMM_EXT_STATS_EN
      chk("m_out_count", 32'(out_count), 32'(pops_m));
`endif
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [15:0] imm, input logic [1:0] mode, input bit ordy);
    bus.in_valid  = v;
    bus.in_imm    = imm;
    bus.in_mode   = mode;
    bus.out_ready = ordy;
  endtask

  initial begin
    drive(0, 16'h0, 2'd0, 0);
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_out_data", bus.out_data, 32'h0);
`ifdef IMM_EXT_STATS_EN
    chk("rst_out_count", 32'(out_count), 32'h0);
`endif
    chk_en = 1'b1;
    rst = 1'b0;

    drive(1, 16'h0013, 2'd0, 1); cyc();
    chk("sign_0013", bus.out_data, 32'h00000013);
    chk("lat_valid", 32'(bus.out_valid), 32'h1);
    drive(1, 16'h801B, 2'd0, 1); cyc(); chk("sign_801b", bus.out_data, 32'hFFFF801B);
    drive(1, 16'h801B, 2'd1, 1); cyc(); chk("zero_801b", bus.out_data, 32'h0000801B);
    drive(1, 16'h801B, 2'd2, 1); cyc(); chk("upper_801b", bus.out_data, 32'h801B0000);
    drive(1, 16'hFFFF, 2'd3, 1); cyc(); chk("branch_ffff", bus.out_data, 32'hFFFFFFFC);
    drive(1, 16'h0004, 2'd3, 1); cyc(); chk("branch_0004", bus.out_data, 32'h00000010);
    drive(0, 16'h0, 2'd0, 1); cyc();

    // Backpressure: fill, offer a third, then drain.
    drive(1, 16'h0001, 2'd0, 0); cyc();
    drive(1, 16'h0002, 2'd0, 0); cyc();
    chk("bp_full_ready", 32'(bus.in_ready), 32'h0);
    drive(1, 16'h0003, 2'd0, 0); cyc();
    chk("bp_hold_data", bus.out_data, 32'h00000001);
    chk("bp_still_full", 32'(bus.in_ready), 32'h0);
    drive(1, 16'h0003, 2'd0, 1); cyc();
    chk("bp_pop2", bus.out_data, 32'h00000002);
    cyc();
    chk("bp_third", bus.out_data, 32'h00000003);
    drive(0, 16'h0, 2'd0, 1); cyc();
    chk("bp_empty", 32'(bus.out_valid), 32'h0);

    // Streaming: push and pop together at count 1.
    for (int i = 0; i < 5; i++) begin
      drive(1, 16'(16'h0010 + i), 2'd0, 1); cyc();
      chk("stream_data", bus.out_data, 32'(16'h0010 + i));
      chk("stream_ready", 32'(bus.in_ready), 32'h1);
    end
    drive(0, 16'h0, 2'd0, 1); cyc();

    // Flush mid-stall with a concurrent offer.
    drive(1, 16'h00A1, 2'd0, 0); cyc();
    drive(1, 16'h00A2, 2'd0, 0); cyc();
    flush = 1'b1; drive(1, 16'h00A3, 2'd0, 0); cyc();
    flush = 1'b0;
    chk("flush_valid", 32'(bus.out_valid), 32'h0);
    chk("flush_ready", 32'(bus.in_ready), 32'h1);
    drive(0, 16'h0, 2'd0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("flush_quiet", 32'(bus.out_valid), 32'h0);
    end

    // Reset mid-stall.
    drive(1, 16'h00B1, 2'd1, 0); cyc();
    drive(1, 16'h00B2, 2'd1, 0); cyc();
    rst = 1'b1; drive(1, 16'h00B3, 2'd1, 0); cyc();
    rst = 1'b0;
    chk("rst2_valid", 32'(bus.out_valid), 32'h0);
    chk("rst2_ready", 32'(bus.in_ready), 32'h1);
    chk("rst2_data", bus.out_data, 32'h0);
`ifdef IMM_EXT_STATS_EN
    chk("rst2_count", 32'(out_count), 32'h0);
`endif
    drive(0, 16'h0, 2'd0, 1); cyc();

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      drive(bit'($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom),
            bit'($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 59) == 0);
      rst   = ($urandom_range(0, 249) == 0);
      cyc();
    end
    rst = 1'b0; flush = 1'b0;
    drive(0, 16'h0, 2'd0, 1); cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
